// File: rtl/mont_pkg.sv
// Shared types for the bit-serial Montgomery multiplier.
// No logic; no latency; no flow control.
package mont_pkg;
   typedef enum logic [1:0] {IDLE, LOOP, SUB} mont_state_t;
   localparam int MONT_DEFAULT_WIDTH = 512;
endpackage

// File: rtl/montgomery_step.sv
// One radix-2 Montgomery iteration: T_next = (T + a_bit*b + q*m) / 2.
// Purely combinational; no flow control.
module montgomery_step
   import mont_pkg::*;
#(
   parameter int WIDTH = MONT_DEFAULT_WIDTH
) (
   input  logic [WIDTH+1:0] t,
   input  logic             a_bit,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH+1:0] t_next
);
   logic [WIDTH+1:0] u_add;
   logic [WIDTH+1:0] u_red;

   // T < 2m keeps both sums below 4m, so WIDTH+2 bits never overflow.
   always_comb begin
      u_add  = t + (a_bit ? {2'b00, b} : '0);
      u_red  = u_add + (u_add[0] ? {2'b00, m} : '0);
      t_next = u_red >> 1;
   end
endmodule

// File: rtl/montgomery_radix2.sv
// Radix-2 Montgomery multiplier, result = a*b*2^-WIDTH mod m; latency WIDTH+1 cycles.
// start accepted only in IDLE; MONT_RESTART_EN lets start abort and relatch mid-operation.
module montgomery_radix2
   import mont_pkg::*;
#(
   parameter  int WIDTH = MONT_DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy
);
   mont_state_t      state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH+1:0] t;
   logic [WIDTH+1:0] t_next;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             t_ge_m;
   logic [WIDTH-1:0] t_sub;

`ifdef MONT_RESTART_EN
   assign accept = start;
`else
   assign accept = start && (state == IDLE);
`endif

   // Multiplicand is consumed LSB-first by shifting, so the step always sees bit 0.
   montgomery_step #(.WIDTH(WIDTH)) u_step (
      .t      (t),
      .a_bit  (a_sh[0]),
      .b      (b_reg),
      .m      (m_reg),
      .t_next (t_next)
   );

   // Final T < 2m, so the truncated difference is exact whenever T >= m.
   assign t_ge_m = (t >= {2'b00, m_reg});
   assign t_sub  = t[WIDTH-1:0] - m_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_reg  <= '0;
         m_reg  <= '0;
         t      <= '0;
         cnt    <= '0;
         result <= '0;
         done   <= 1'b0;
         busy   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sh  <= in_a;
            b_reg <= in_b;
            m_reg <= in_m;
            t     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOOP;
         end else begin
            case (state)
               LOOP: begin
                  t    <= t_next;
                  a_sh <= a_sh >> 1;
                  cnt  <= cnt + 1'b1;
                  if (cnt == CNT_W'(WIDTH - 1)) begin
                     state <= SUB;
                  end
               end
               SUB: begin
                  result <= t_ge_m ? t_sub : t[WIDTH-1:0];
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_montgomery_radix2.sv
// Scoreboard bench for montgomery_radix2 at WIDTH=8 and WIDTH=64.
module tb_montgomery_radix2;
   localparam int W8  = 8;
   localparam int W64 = 64;

   logic clk = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   logic          start8 = 1'b0;
   logic [7:0]    a8 = '0, b8 = '0, m8 = '0;
   logic [7:0]    res8;
   logic          done8, busy8;
   logic          start64 = 1'b0;
   logic [63:0]   a64 = '0, b64 = '0, m64 = '0;
   logic [63:0]   res64;
   logic          done64, busy64;

   montgomery_radix2 #(.WIDTH(W8)) dut8 (
      .clk(clk), .resetn(resetn), .start(start8), .in_a(a8), .in_b(b8), .in_m(m8),
      .result(res8), .done(done8), .busy(busy8)
   );
   montgomery_radix2 #(.WIDTH(W64)) dut64 (
      .clk(clk), .resetn(resetn), .start(start64), .in_a(a64), .in_b(b64), .in_m(m64),
      .result(res64), .done(done64), .busy(busy64)
   );

   typedef struct {
      logic [63:0] val;
      longint      t0;
   } exp_t;

   exp_t        q8[$];
   exp_t        q64[$];
   int          total = 0;
   int          bad = 0;
   longint      cyc = 0;
   logic [7:0]  held8 = '0;
   logic        done8_d = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain modular product, then divide by 2 modulo m, w times.
   function automatic logic [63:0] mont_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] m, input int w);
      logic [127:0] x;
      x = (128'(a) * 128'(b)) % 128'(m);
      for (int i = 0; i < w; i++) begin
         if (x[0]) x = (x + 128'(m)) >> 1;
         else      x = x >> 1;
      end
      return x[63:0];
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
         held8 = '0;
      end else if (done8) begin
         if (q8.size() == 0) begin
            check("spurious_done8", 64'(q8.size()), 1);
         end else begin
            e = q8.pop_front();
            check("res8", res8, e.val);
            check("lat8", 64'(cyc - e.t0), W8 + 1);
            check("busy_at_done8", busy8, 0);
            check("done_width8", done8_d, 0);
            held8 = e.val[7:0];
         end
      end else begin
         check("hold8", res8, held8);
      end
      done8_d = done8;
   end

   always @(negedge clk) begin
      exp_t e;
      if (resetn && done64) begin
         if (q64.size() == 0) begin
            check("spurious_done64", 64'(q64.size()), 1);
         end else begin
            e = q64.pop_front();
            check("res64", res64, e.val);
            check("lat64", 64'(cyc - e.t0), W64 + 1);
         end
      end
   end

   // Called at #1 after an edge; the next edge samples start.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
      logic acc;
      logic restart;
      start8 = 1'b1;
      a8 = a; b8 = b; m8 = m;
      restart = busy8;
`ifdef MONT_RESTART_EN
      acc = 1'b1;
`else
      acc = !busy8;
`endif
      @(posedge clk); #1;
      start8 = 1'b0;
      if (acc) begin
         if (restart && q8.size() > 0) q8.delete(q8.size() - 1);
         q8.push_back('{mont_ref(64'(a), 64'(b), 64'(m), W8), cyc});
         check("busy_after_start8", busy8, 1);
      end
   endtask

   task automatic wait_done8(input int budget, input bit scramble);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(posedge clk); #1;
         if (scramble) begin
            a8 = 8'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
         end
         if (done8) found = 1'b1;
      end
      check("timeout8", found, 1);
   endtask

   task automatic wait_done64(input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(posedge clk); #1;
         if (done64) found = 1'b1;
      end
      check("timeout64", found, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  ra, rb, rm;
      logic [63:0] xa, xb, xm;
      #1 resetn = 1'b0;
      #1;
      check("rst_res8", res8, 0);
      check("rst_done8", done8, 0);
      check("rst_busy8", busy8, 0);
      check("rst_res64", res64, 0);
      check("rst_busy64", busy64, 0);
      #20;
      @(negedge clk); #2 resetn = 1'b1;
      @(posedge clk); #1;

      op8(8'd1, 8'd1, 8'd13);
      wait_done8(20, 1'b0);
      check("tp_one", res8, 3);

      op8(8'd9, 8'd9, 8'd13);
      wait_done8(20, 1'b0);
      check("tp_r", res8, 9);
      op8(8'd0, 8'd12, 8'd13);
      wait_done8(20, 1'b0);
      check("tp_b2b", res8, 0);

      op8(8'd0, 8'd0, 8'd1);
      wait_done8(20, 1'b0);
      check("m_one", res8, 0);

      op8(8'd200, 8'd123, 8'd251);
      wait_done8(20, 1'b1);

      // Re-pulse start mid-operation with new operands.
      op8(8'd9, 8'd9, 8'd13);
      repeat (5) begin @(posedge clk); #1; end
      op8(8'd2, 8'd3, 8'd13);
      wait_done8(30, 1'b0);
`ifdef MONT_RESTART_EN
      check("restart_res", res8, 5);
`else
      check("restart_res", res8, 9);
`endif
      repeat (12) begin @(posedge clk); #1; end

      // Asynchronous reset mid-operation aborts silently.
      op8(8'd7, 8'd11, 8'd13);
      repeat (3) begin @(posedge clk); #1; end
      #2 resetn = 1'b0;
      #1;
      check("abort_res8", res8, 0);
      check("abort_busy8", busy8, 0);
      check("abort_done8", done8, 0);
      q8.delete();
      @(negedge clk); #2 resetn = 1'b1;
      repeat (12) begin @(posedge clk); #1; end
      op8(8'd7, 8'd11, 8'd13);
      wait_done8(20, 1'b0);

      for (int k = 0; k < 30; k++) begin
         rm = 8'($urandom_range(1, 255)) | 8'd1;
         ra = 8'($urandom) % rm;
         rb = 8'($urandom) % rm;
         op8(ra, rb, rm);
         wait_done8(20, 1'b0);
      end

      for (int k = 0; k < 12; k++) begin
         xm = {$urandom, $urandom} | 64'd1;
         if (k == 0) xm = 64'hffff_ffff_ffff_ffc5;
         xa = {$urandom, $urandom} % xm;
         xb = {$urandom, $urandom} % xm;
         start64 = 1'b1;
         a64 = xa; b64 = xb; m64 = xm;
         @(posedge clk); #1;
         start64 = 1'b0;
         q64.push_back('{mont_ref(xa, xb, xm, W64), cyc});
         wait_done64(80);
      end

      repeat (3) begin @(posedge clk); #1; end
      check("q8_drained", 64'(q8.size()), 0);
      check("q64_drained", 64'(q64.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
